// File: rtl/sram_axis_reader_if.sv
// Bus bundle for sram_axis_reader: SRAM read port plus AXI4-Stream master channel.
// master = the reader, slave = the SRAM/stream sink environment.
interface sram_axis_reader_if #(
  parameter int C_AXIS_TDATA_WIDTH = 8,
  parameter int ADDR_WIDTH         = 16,
  parameter int IDX_WIDTH          = 2,
  parameter int SRAM_WIDTH         = 32
);
  logic                          sram_out_en;
  logic [IDX_WIDTH-1:0]          sram_out_idx;
  logic [ADDR_WIDTH-1:0]         sram_out_addr;
  logic signed [SRAM_WIDTH-1:0]  sram_out_data;

  logic [C_AXIS_TDATA_WIDTH-1:0] m_axis_tdata;
  logic                          m_axis_tvalid;
  logic                          m_axis_tready;
  logic                          m_axis_tlast;

  modport master (
    output sram_out_en, sram_out_idx, sram_out_addr,
    input  sram_out_data,
    output m_axis_tdata, m_axis_tvalid, m_axis_tlast,
    input  m_axis_tready
  );

  modport slave (
    input  sram_out_en, sram_out_idx, sram_out_addr,
    output sram_out_data,
    input  m_axis_tdata, m_axis_tvalid, m_axis_tlast,
    output m_axis_tready
  );
endinterface

// File: rtl/sram_axis_reader.sv
// Streams a block of SRAM words out over AXI4-Stream through a 3-entry credit FIFO.
// Optional macro SRAM_READER_SAT_EN: signed-saturate each word to the beat width instead of truncating.
module sram_axis_reader #(
  parameter int C_AXIS_TDATA_WIDTH = 8,
  parameter int ADDR_WIDTH         = 16,
  parameter int IDX_WIDTH          = 2,
  parameter int SRAM_WIDTH         = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic [IDX_WIDTH-1:0]  src_idx,
  output logic                  busy,
  output logic                  done,
  sram_axis_reader_if.master    bus
);

  localparam int DW         = C_AXIS_TDATA_WIDTH;
  localparam int FIFO_DEPTH = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic [IDX_WIDTH-1:0]  rd_idx_q;
  logic [ADDR_WIDTH:0]   rd_left_q;
  logic [ADDR_WIDTH:0]   beat_left_q;
  logic                  done_q;

  logic                  issue_p0;
  logic                  rd_vld_p1;
  logic [DW-1:0]         word_p1;

  logic [DW-1:0]         fifo_mem [FIFO_DEPTH];
  logic [1:0]            wr_ptr_q, rd_ptr_q;
  logic [1:0]            fifo_cnt_q;

  logic                  push, pop, tlast;
  logic [2:0]            occ;
  logic                  start_xfer, start_empty;

`ifdef SRAM_READER_SAT_EN
  localparam logic signed [SRAM_WIDTH-1:0] SAT_MAX =
    SRAM_WIDTH'((64'sd1 <<< (DW-1)) - 64'sd1);
  localparam logic signed [SRAM_WIDTH-1:0] SAT_MIN = ~SAT_MAX;
`endif

  function automatic logic [DW-1:0] fmt_word(input logic signed [SRAM_WIDTH-1:0] w);
`ifdef SRAM_READER_SAT_EN
    if (w > SAT_MAX)      return DW'(SAT_MAX);
    else if (w < SAT_MIN) return DW'(SAT_MIN);
    else                  return DW'(w);
`else
    return DW'(w);
`endif
  endfunction

  function automatic logic [1:0] ptr_next(input logic [1:0] p);
    return (p == 2'(FIFO_DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  assign start_xfer  = (state_q == IDLE) && start && (length != '0);
  assign start_empty = (state_q == IDLE) && start && (length == '0);

  assign push  = rd_vld_p1;
  assign pop   = bus.m_axis_tvalid && bus.m_axis_tready;
  // Occupancy the FIFO will hold once this cycle's push/pop settle; an issue
  // now lands next cycle, so it is allowed only while that stays below depth.
  assign occ   = 3'(fifo_cnt_q) + 3'(push) - 3'(pop);
  assign tlast = bus.m_axis_tvalid && (beat_left_q == (ADDR_WIDTH+1)'(1));

  always_comb begin
    state_d  = state_q;
    issue_p0 = 1'b0;
    unique case (state_q)
      IDLE:  if (start_xfer) state_d = READ;
      READ: begin
        if (occ < 3'(FIFO_DEPTH)) begin
          issue_p0 = 1'b1;
          if (rd_left_q == (ADDR_WIDTH+1)'(1)) state_d = DRAIN;
        end
      end
      DRAIN: if (pop && tlast) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // p0: read issue stage -- address/strobe to SRAM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      rd_addr_q   <= '0;
      rd_idx_q    <= '0;
      rd_left_q   <= '0;
      beat_left_q <= '0;
      done_q      <= 1'b0;
      rd_vld_p1   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_vld_p1 <= issue_p0;
      done_q    <= start_empty || ((state_q == DRAIN) && pop && tlast);
      if (start_xfer) begin
        rd_addr_q   <= base_addr;
        rd_idx_q    <= src_idx;
        rd_left_q   <= length;
        beat_left_q <= length;
      end else begin
        if (issue_p0) begin
          rd_addr_q <= rd_addr_q + ADDR_WIDTH'(1);
          rd_left_q <= rd_left_q - (ADDR_WIDTH+1)'(1);
        end
        if (pop) beat_left_q <= beat_left_q - (ADDR_WIDTH+1)'(1);
      end
    end
  end

  // p1: SRAM data returns, formatted and pushed into the FIFO
  assign word_p1 = fmt_word(bus.sram_out_data);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr_q] <= word_p1;
        wr_ptr_q           <= ptr_next(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_next(rd_ptr_q);
      fifo_cnt_q <= fifo_cnt_q + 2'(push) - 2'(pop);
    end
  end

  // p2: FIFO head drives the stream
  assign bus.m_axis_tvalid = (fifo_cnt_q != 2'd0);
  assign bus.m_axis_tdata  = fifo_mem[rd_ptr_q];
  assign bus.m_axis_tlast  = tlast;

  assign bus.sram_out_en   = issue_p0;
  assign bus.sram_out_addr = rd_addr_q;
  assign bus.sram_out_idx  = rd_idx_q;

  assign busy = (state_q != IDLE);
  assign done = done_q;

endmodule

// File: doc/sram_axis_reader.md
SRAM_AXIS_READER -- requirements
Module: sram_axis_reader

Interface
REQ-001 SHALL have parameter C_AXIS_TDATA_WIDTH, default 8: AXI4-Stream beat width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16: SRAM word address width.
REQ-003 SHALL have parameter IDX_WIDTH, default 2: SRAM bank select width.
REQ-004 SHALL have parameter SRAM_WIDTH, default 32: SRAM read word width, SRAM_WIDTH >= C_AXIS_TDATA_WIDTH.
REQ-005 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port start, input, 1: one-cycle transfer request, sampled only in IDLE.
REQ-008 SHALL have port base_addr, input, ADDR_WIDTH: first word address.
REQ-009 SHALL have port length, input, ADDR_WIDTH+1: word count; 0 is legal.
REQ-010 SHALL have port src_idx, input, IDX_WIDTH: bank to read.
REQ-011 SHALL have port busy, output, 1: transfer in progress.
REQ-012 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-013 SHALL have port sram_out_en, output, 1: SRAM read strobe.
REQ-014 SHALL have port sram_out_idx, output, IDX_WIDTH: bank select, equal to latched src_idx.
REQ-015 SHALL have port sram_out_addr, output, ADDR_WIDTH: read address.
REQ-016 SHALL have port sram_out_data, input, SRAM_WIDTH signed: read data, valid exactly one cycle after the sram_out_en cycle.
REQ-017 SHALL have port m_axis_tdata, output, C_AXIS_TDATA_WIDTH: stream data.
REQ-018 SHALL have port m_axis_tvalid, output, 1: stream valid.
REQ-019 SHALL have port m_axis_tready, input, 1: stream ready.
REQ-020 SHALL have port m_axis_tlast, output, 1: marks the final beat.

Function
REQ-021 SHALL implement FSM IDLE -> READ -> DRAIN -> IDLE.
REQ-022 IDLE: on start with length>0, SHALL latch base_addr/length/src_idx and enter READ; with length=0, SHALL pulse done next cycle, emit no beat, and stay in IDLE.
REQ-023 READ: SHALL assert sram_out_en for one address per cycle while (FIFO count + reads in flight - pop this cycle) < 3; address increments by 1 and wraps modulo 2^ADDR_WIDTH.
REQ-024 SHALL enter DRAIN on the cycle after the last read issue; DRAIN -> IDLE on the tlast handshake.
REQ-025 SHALL capture sram_out_data into a 3-entry FIFO one cycle after each read issue; the FIFO SHALL never overflow.
REQ-026 m_axis_tvalid SHALL equal FIFO non-empty; m_axis_tdata SHALL be the FIFO head.
REQ-027 Once tvalid is high, tdata/tlast SHALL hold stable until tvalid & tready.
REQ-028 m_axis_tlast SHALL be high only on beat number length (1-based).
REQ-029 Latency: start at cycle T -> first sram_out_en at T+1 -> first tvalid at T+3.
REQ-030 With tready held high, throughput SHALL be 1 beat per cycle after the first beat.
REQ-031 tready low SHALL stall read issue once the FIFO credit limit is reached; no beat is lost or duplicated.
REQ-032 busy SHALL be high from T+1 until the tlast handshake cycle inclusive; done SHALL pulse the cycle after it.
REQ-033 start while busy SHALL be ignored.

Reset
REQ-034 On rst low, regardless of clock, SHALL force IDLE, empty the FIFO, clear in-flight tracking, and drive busy, done, sram_out_en, m_axis_tvalid, and m_axis_tlast to 0.
REQ-035 On rst low, SHALL drive sram_out_addr, sram_out_idx, and m_axis_tdata to 0.
REQ-036 Reset mid-transfer SHALL abort the transfer with no further beats and no done pulse.

Configuration
REQ-037 With macro SRAM_READER_SAT_EN defined, each word SHALL be signed-saturated to the C_AXIS_TDATA_WIDTH range (8-bit: -128..127).
REQ-038 Without SRAM_READER_SAT_EN, tdata SHALL be sram_out_data[C_AXIS_TDATA_WIDTH-1:0] (truncation).

Verification
REQ-039 base_addr=0x10, length=4, src_idx=1, tready=1, SRAM words 1,2,3,4 -> addrs 0x10..0x13 on bank 1, beats 1,2,3,4 on consecutive cycles, tlast on beat 4, then done.
REQ-040 length=0 -> no sram_out_en, no tvalid, done one cycle after start.
REQ-041 length=6, tready toggling 1,0,0,1,... -> exactly 6 beats in order, tdata stable during stalls, at most 3 reads outstanding.
REQ-042 base_addr=0xFFFE, length=4 -> addrs 0xFFFE, 0xFFFF, 0x0000, 0x0001.
REQ-043 word 300 -> 127 with SRAM_READER_SAT_EN, 44 (0x2C) without; word -200 -> -128 with macro, 0x38 without.
REQ-044 rst low after the 2nd beat of length=8 -> tvalid/busy/done 0 immediately; a new start with length=2 afterwards completes normally.
